// File: rtl/mul_hilo_unit.sv
// Unsigned 32x32 shift-add multiplier with HI/LO result registers.
// The controller clocks one multiply step per MUL cycle and finishes the
// run with a HILO_WR cycle that performs the last step and commits HI/LO.
// Protocol violations abort the run and raise a sticky err flag.
module mul_hilo_unit #(
    parameter logic [5:0] MUL     = 6'b011011,
    parameter logic [5:0] MFHI    = 6'b010000,
    parameter logic [5:0] MFLO    = 6'b010010,
    parameter logic [5:0] HILO_WR = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Signal,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic [31:0] dataOut,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [4:0] LAST_CNT = 5'd31;

    state_t      state;
    state_t      nextState;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] mcand;
    logic [31:0] mplr;
    logic [63:0] prod;
    logic [4:0]  cnt;
    logic        overrun;   // an overrun happened in this run; blocks the commit

    logic        doStart;
    logic        doStep;
    logic        doCommit;
    logic        doAbort;
    logic        doOverrun;
    logic        setErr;
    logic [63:0] stepProd;
    logic [63:0] startProd;

    // Partial product after one iteration, and the product after iteration 0.
    assign stepProd  = prod + (mplr[0] ? mcand : 64'd0);
    assign startProd = dataB[0] ? {32'd0, dataA} : 64'd0;
    assign busy      = (state == RUN);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state and control decode from the current state and Signal.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        nextState = state;
        doStart   = 1'b0;
        doStep    = 1'b0;
        doCommit  = 1'b0;
        doAbort   = 1'b0;
        doOverrun = 1'b0;
        setErr    = 1'b0;
        case (state)
            IDLE: begin
                if (Signal == MUL) begin
                    doStart   = 1'b1;
                    nextState = RUN;
                end else if (Signal == HILO_WR) begin
                    setErr = 1'b1;
                end
            end
            RUN: begin
                if (Signal == MUL) begin
                    if (cnt != LAST_CNT) begin
                        doStep = 1'b1;
                    end else begin
                        doOverrun = 1'b1;
                        setErr    = 1'b1;
                    end
                end else if (Signal == HILO_WR && cnt == LAST_CNT && !overrun) begin
                    doCommit  = 1'b1;
                    nextState = IDLE;
                end else begin
                    // Early HILO_WR, HILO_WR after an overrun, or any foreign code.
                    doAbort   = 1'b1;
                    setErr    = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Multiply datapath, HI/LO commit and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= 64'd0;
            mplr    <= 32'd0;
            prod    <= 64'd0;
            cnt     <= 5'd0;
            overrun <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (doStart) begin
                // Latch operands and apply iteration 0 in the same edge.
                mcand   <= {31'd0, dataA, 1'b0};
                mplr    <= {1'b0, dataB[31:1]};
                prod    <= startProd;
                cnt     <= 5'd1;
                overrun <= 1'b0;
            end else if (doStep) begin
                prod  <= stepProd;
                mcand <= {mcand[62:0], 1'b0};
                mplr  <= {1'b0, mplr[31:1]};
                cnt   <= cnt + 5'd1;
            end else if (doCommit) begin
                prod <= stepProd;
                hi   <= stepProd[63:32];
                lo   <= stepProd[31:0];
                cnt  <= 5'd0;
            end else if (doAbort) begin
                cnt <= 5'd0;
            end

            if (doOverrun) overrun <= 1'b1;

            done <= doCommit;

            if (doStart)     err <= 1'b0;
            else if (setErr) err <= 1'b1;
        end
    end

    // Registered HI/LO readout; holds unless a read code is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataOut <= 32'd0;
        end else if (Signal == MFHI) begin
            dataOut <= hi;
        end else if (Signal == MFLO) begin
            dataOut <= lo;
        end
    end

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Self-checking bench for mul_hilo_unit: a transaction-level model (operands
// latched at start, result = a*b, MUL-count bookkeeping) is compared against
// the DUT every cycle, plus literal expectations for the directed scenarios.
module tb_mul_hilo_unit;

    localparam logic [5:0] MUL     = 6'b011011;
    localparam logic [5:0] MFHI    = 6'b010000;
    localparam logic [5:0] MFLO    = 6'b010010;
    localparam logic [5:0] HILO_WR = 6'b111111;
    localparam logic [5:0] ADD     = 6'b100000;

    logic        clk;
    logic        reset;
    logic [5:0]  Signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] dataOut;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    bit compareOn = 1'b0;

    mul_hilo_unit dut (
        .clk     (clk),
        .reset   (reset),
        .Signal  (Signal),
        .dataA   (dataA),
        .dataB   (dataB),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level view of the unit.
    typedef struct packed {
        logic        run;     // a multiply is in progress
        logic [5:0]  muls;    // MUL cycles accepted in this run (start included)
        logic        poison;  // an overrun occurred in this run
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] dout;
        logic        done;
        logic        err;
    } mdl_t;

    mdl_t mdl;

    function automatic mdl_t modelNext(mdl_t m, logic rst, logic [5:0] sig,
                                       logic [31:0] a, logic [31:0] b);
        mdl_t n;
        logic [63:0] product;
        if (rst) begin
            n = '0;
            return n;
        end
        n = m;
        n.done = 1'b0;
        if (sig == MFHI) n.dout = m.hi;
        else if (sig == MFLO) n.dout = m.lo;
        if (!m.run) begin
            if (sig == MUL) begin
                n.run = 1'b1; n.a = a; n.b = b; n.muls = 6'd1;
                n.poison = 1'b0; n.err = 1'b0;
            end else if (sig == HILO_WR) begin
                n.err = 1'b1;
            end
        end else if (sig == MUL) begin
            if (m.muls < 6'd31) n.muls = m.muls + 6'd1;
            else begin n.err = 1'b1; n.poison = 1'b1; end
        end else if (sig == HILO_WR && m.muls == 6'd31 && !m.poison) begin
            product = {32'd0, m.a} * {32'd0, m.b};
            n.hi = product[63:32];
            n.lo = product[31:0];
            n.done = 1'b1;
            n.run = 1'b0;
        end else begin
            n.run = 1'b0;
            n.err = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk) mdl <= modelNext(mdl, reset, Signal, dataA, dataB);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (compareOn) begin
            check("busy",    32'(busy),    32'(mdl.run));
            check("done",    32'(done),    32'(mdl.done));
            check("err",     32'(err),     32'(mdl.err));
            check("dataOut", dataOut,      mdl.dout);
        end
    end

    // Present a code for one clock; returns at the following falling edge.
    task automatic cyc(input logic [5:0] sig);
        Signal = sig;
        @(negedge clk);
    endtask

    task automatic mulCycles(input int n);
        for (int i = 0; i < n; i++) cyc(MUL);
    endtask

    initial begin
        reset = 1'b1; Signal = 6'd0; dataA = 32'd0; dataB = 32'd0;
        @(negedge clk);
        @(negedge clk);
        compareOn = 1'b1;
        reset = 1'b0;

        // Reset state readout.
        cyc(MFHI);
        check("reset_dataOut", dataOut, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_err", 32'(err), 32'h0);

        // 3 * 5, read LO immediately after the commit.
        dataA = 32'd3; dataB = 32'd5;
        mulCycles(31);
        check("run_busy", 32'(busy), 32'h1);
        cyc(HILO_WR);
        check("commit_done", 32'(done), 32'h1);
        check("commit_busy", 32'(busy), 32'h0);
        cyc(MFLO);
        check("done_one_cycle", 32'(done), 32'h0);
        check("lo_3x5", dataOut, 32'h0000000F);
        cyc(MFHI);
        check("hi_3x5", dataOut, 32'h00000000);
        check("err_3x5", 32'(err), 32'h0);

        // Aborted run by a foreign code keeps HI/LO.
        dataA = 32'd7; dataB = 32'd9;
        mulCycles(10);
        cyc(ADD);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_err", 32'(err), 32'h1);
        cyc(MFLO);
        check("abort_lo_kept", dataOut, 32'h0000000F);

        // Max operands with dataA disturbed mid-run; also clears err on start.
        dataA = 32'hFFFFFFFF; dataB = 32'hFFFFFFFF;
        cyc(MUL);
        check("start_clears_err", 32'(err), 32'h0);
        mulCycles(9);
        dataA = 32'd0;
        mulCycles(21);
        cyc(HILO_WR);
        cyc(MFHI);
        check("hi_max", dataOut, 32'hFFFFFFFE);
        cyc(MFLO);
        check("lo_max", dataOut, 32'h00000001);

        // Early HILO_WR.
        dataA = 32'd11; dataB = 32'd13;
        mulCycles(5);
        cyc(HILO_WR);
        check("early_done", 32'(done), 32'h0);
        check("early_err", 32'(err), 32'h1);
        cyc(MFLO);
        check("early_lo_kept", dataOut, 32'h00000001);

        // Overrun: 32 MUL then HILO_WR must not commit.
        mulCycles(32);
        check("overrun_err", 32'(err), 32'h1);
        check("overrun_busy", 32'(busy), 32'h1);
        cyc(HILO_WR);
        check("overrun_done", 32'(done), 32'h0);
        cyc(MFHI);
        check("overrun_hi_kept", dataOut, 32'hFFFFFFFE);

        // HILO_WR while idle only raises err.
        cyc(HILO_WR);
        check("idle_wr_err", 32'(err), 32'h1);
        check("idle_wr_busy", 32'(busy), 32'h0);

        // Reset in the middle of a run.
        dataA = 32'd21; dataB = 32'd4;
        mulCycles(14);
        reset = 1'b1;
        cyc(MUL);
        reset = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_dataOut", dataOut, 32'h0);
        cyc(MFHI);
        check("rst_mid_hi", dataOut, 32'h0);
        cyc(MFLO);
        check("rst_mid_lo", dataOut, 32'h0);

        // Random full multiplies with operands disturbed during the run.
        for (int t = 0; t < 20; t++) begin
            dataA = $urandom; dataB = $urandom;
            if (t == 0) dataB = 32'h80000001;
            for (int i = 0; i < 31; i++) begin
                cyc(MUL);
                if ($urandom_range(3) == 0) dataA = $urandom;
                if ($urandom_range(3) == 0) dataB = $urandom;
            end
            cyc(HILO_WR);
            cyc(MFHI);
            cyc(MFLO);
        end

        // Random code mix, including occasional resets.
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [5:0] sig;
            r = int'($urandom_range(99));
            if (r < 80)      sig = MUL;
            else if (r < 86) sig = HILO_WR;
            else if (r < 91) sig = MFHI;
            else if (r < 96) sig = MFLO;
            else             sig = 6'($urandom);
            reset = ($urandom_range(199) == 0);
            if ($urandom_range(7) == 0) dataA = $urandom;
            if ($urandom_range(7) == 0) dataB = $urandom;
            cyc(sig);
        end
        reset = 1'b0;
        cyc(MFHI);
        cyc(MFLO);

        compareOn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_hilo_unit.md
MUL_HILO_UNIT -- requirements
Module: mul_hilo_unit

Interface
REQ-001 Parameters SHALL be, one per line: MUL, 6'b011011, multiply-step code; MFHI, 6'b010000, read-HI code; MFLO, 6'b010010, read-LO code; HILO_WR, 6'b111111, final-step-and-commit code.
REQ-002 The module SHALL have one clock and a synchronous, active-high reset; the ports are listed below.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 Signal  input  6  control code, driven registered from the ALU controller's multiplier output.
REQ-006 dataA  input  32  multiplicand, unsigned.
REQ-007 dataB  input  32  multiplier, unsigned.
REQ-008 dataOut  output  32  registered HI/LO readout.
REQ-009 busy  output  1  high while a multiply is in progress (state RUN).
REQ-010 done  output  1  one-cycle pulse after a HI/LO commit.
REQ-011 err  output  1  sticky protocol-error flag.

Function
REQ-012 The block SHALL hold internal registers HI[31:0], LO[31:0], MCAND[63:0], MPLR[31:0], PROD[63:0], cnt[4:0], and state in {IDLE, RUN}.
REQ-013 The multiply SHALL be unsigned shift-add, one iteration per step: if MPLR[0] then PROD += MCAND; then MCAND <<= 1 and MPLR >>= 1.
REQ-014 In IDLE with Signal==MUL, the block SHALL latch MCAND={32'b0,dataA} and MPLR=dataB, apply iteration 0 with PROD starting from 0, set cnt=1, clear err, and go to RUN.
REQ-015 Operands SHALL be sampled only at start; later changes to dataA/dataB SHALL have no effect.
REQ-016 In RUN with Signal==MUL and cnt<31, the block SHALL perform one iteration and increment cnt.
REQ-017 In RUN with Signal==HILO_WR and cnt==31, the block SHALL perform the final iteration, write HI=result[63:32] and LO=result[31:0] in the same edge, pulse done high for the next cycle, and return to IDLE.
REQ-018 A full multiply SHALL therefore be exactly 31 MUL cycles followed by 1 HILO_WR cycle (32 iterations), with results readable from the cycle after commit.
REQ-019 In RUN with Signal==MUL and cnt==31 (overrun), the block SHALL hold PROD/cnt and set err.
REQ-020 In RUN with Signal==HILO_WR and cnt!=31, the block SHALL abort to IDLE without commit, set err, and keep HI/LO unchanged.
REQ-021 In RUN with any other code (including MFHI/MFLO), the block SHALL abort to IDLE, set err, and keep HI/LO unchanged.
REQ-022 In IDLE with Signal==HILO_WR, the block SHALL set err and change nothing else.
REQ-023 err SHALL remain set until reset or the next accepted start.
REQ-024 On Signal==MFHI, dataOut SHALL load HI at that edge; on MFLO it SHALL load LO; otherwise dataOut SHALL hold (1-cycle read latency).
REQ-025 An MFHI/MFLO issued in the cycle right after a commit SHALL read the newly committed value.
REQ-026 busy SHALL equal (state==RUN).
REQ-027 done SHALL be low in every cycle other than the one following a commit.

Reset
REQ-028 On reset, the block SHALL clear state to IDLE, cnt=0, PROD=MCAND=MPLR=0, HI=LO=0, dataOut=0, and busy=done=err=0.
REQ-029 Reset SHALL take priority over every Signal value, including mid-RUN; an interrupted multiply SHALL never commit.

Verification
REQ-030 Reset, then MFHI -> dataOut=0x00000000, busy=0, err=0.
REQ-031 A=3, B=5, 31 MUL + HILO_WR -> done pulse one cycle; MFLO -> 0x0000000F; MFHI -> 0x00000000; err=0.
REQ-032 A=B=0xFFFFFFFF, full sequence, with dataA changed to 0 at cycle 10 -> MFHI=0xFFFFFFFE, MFLO=0x00000001.
REQ-033 After REQ-031, start A=7,B=9, 10 MUL then ADD (6'b100000) -> busy=0, err=1, MFLO still 0x0000000F.
REQ-034 HILO_WR after 5 MUL -> no commit, no done, err=1; 32 MUL + HILO_WR -> overrun err=1, no commit.
REQ-035 Reset asserted at MUL cycle 15 -> next cycle busy=0, HI=LO=dataOut=0, done never pulses.
